// File: rtl/std_lane_pkg.sv
// rtl/std_lane_pkg.sv - shared encodings and types for the std lane stream buffer
package std_lane_pkg;

    localparam int LANE_DATA_W = 32;

    typedef enum logic [1:0] {
        CNTL_MOM     = 2'b00,
        CNTL_SOM     = 2'b01,
        CNTL_EOM     = 2'b10,
        CNTL_SOM_EOM = 2'b11
    } cntl_e;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_MSG = 1'b1
    } framer_state_e;

    // Packing order {cntl, data, mask} is also the flat FIFO entry layout used by the top.
    typedef struct packed {
        cntl_e                  cntl;
        logic [LANE_DATA_W-1:0] data;
        logic [LANE_DATA_W-1:0] mask;
    } strm_entry_t;

endpackage

// File: rtl/std_lane_strm_fifo.sv
// rtl/std_lane_strm_fifo.sv - first-word-fall-through FIFO holding one stream's entries
module std_lane_strm_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 66
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic                      pop,
    input  logic [ENTRY_W-1:0]        wr_entry,
    output logic [ENTRY_W-1:0]        rd_entry,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    // A push at full with a pop lands in the slot being read out this same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (count == '0);
    assign full     = count[AW];
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/std_lane_strm_buffer.sv
// rtl/std_lane_strm_buffer.sv - elastic multi-stream lane buffer with framing checks and lockstep pop
module std_lane_strm_buffer
    import std_lane_pkg::*;
#(
    parameter int NUM_STRM  = 2,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int SLACK     = 2,
    parameter int CNT_W     = 16,
    parameter int LOCK_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic [1:0]                   std__pe__lane_type,
    input  logic [NUM_STRM-1:0]          std__pe__lane_strm_data_valid,
    input  logic [2*NUM_STRM-1:0]        std__pe__lane_strm_cntl,
    input  logic [DATA_W*NUM_STRM-1:0]   std__pe__lane_strm_data,
    input  logic [DATA_W*NUM_STRM-1:0]   std__pe__lane_strm_data_mask,
    output logic [NUM_STRM-1:0]          pe__std__lane_strm_ready,
    output logic [NUM_STRM-1:0]          sti__stOp__lane_strm_data_valid,
    output logic [2*NUM_STRM-1:0]        sti__stOp__lane_strm_cntl,
    output logic [DATA_W*NUM_STRM-1:0]   sti__stOp__lane_strm_data,
    output logic [DATA_W*NUM_STRM-1:0]   sti__stOp__lane_strm_data_mask,
    input  logic [NUM_STRM-1:0]          stOp__sti__lane_strm_ready,
    output logic [1:0]                   sti__stOp__lane_type,
    output logic [CNT_W*NUM_STRM-1:0]    strm_msg_count,
    output logic [NUM_STRM-1:0]          strm_frame_err,
    output logic [NUM_STRM-1:0]          strm_overflow_err
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 2 + 2 * DATA_W;
    localparam logic [AW:0] READY_LIMIT = DEPTH[AW:0] - SLACK[AW:0];

    logic [NUM_STRM-1:0] empty, full, push, pop, out_valid;
    logic [AW:0]         count      [NUM_STRM];
    logic [AW:0]         count_next [NUM_STRM];
    logic [ENTRY_W-1:0]  wr_entry   [NUM_STRM];
    logic [ENTRY_W-1:0]  rd_entry   [NUM_STRM];

    logic [NUM_STRM-1:0] ready_q, ready_d;
    logic [NUM_STRM-1:0] frame_err_q, frame_err_d;
    logic [NUM_STRM-1:0] overflow_q, overflow_d;
    logic [1:0]          lane_type_q, lane_type_d;
    framer_state_e       fr_state_q [NUM_STRM];
    framer_state_e       fr_state_d [NUM_STRM];
    logic [CNT_W-1:0]    msg_cnt_q  [NUM_STRM];
    logic [CNT_W-1:0]    msg_cnt_d  [NUM_STRM];

    for (genvar s = 0; s < NUM_STRM; s++) begin : g_strm
        assign wr_entry[s] = {std__pe__lane_strm_cntl[2*s +: 2],
                              std__pe__lane_strm_data[DATA_W*s +: DATA_W],
                              std__pe__lane_strm_data_mask[DATA_W*s +: DATA_W]};

        std_lane_strm_fifo #(
            .DEPTH   (DEPTH),
            .ENTRY_W (ENTRY_W)
        ) u_fifo (
            .clk      (clk),
            .resetn   (reset_poweron),
            .push     (push[s]),
            .pop      (pop[s]),
            .wr_entry (wr_entry[s]),
            .rd_entry (rd_entry[s]),
            .count    (count[s]),
            .empty    (empty[s]),
            .full     (full[s])
        );

        assign sti__stOp__lane_strm_cntl[2*s +: 2]           = rd_entry[s][ENTRY_W-1 -: 2];
        assign sti__stOp__lane_strm_data[DATA_W*s +: DATA_W]      = rd_entry[s][2*DATA_W-1 -: DATA_W];
        assign sti__stOp__lane_strm_data_mask[DATA_W*s +: DATA_W] = rd_entry[s][DATA_W-1:0];
        assign strm_msg_count[CNT_W*s +: CNT_W]              = msg_cnt_q[s];
    end

    // Lockstep releases operands only when every stream has a head and every consumer is ready.
    always_comb begin
        for (int s = 0; s < NUM_STRM; s++) begin
            if (LOCK_MODE != 0) begin
                out_valid[s] = &(~empty);
                pop[s]       = (&(~empty)) & (&stOp__sti__lane_strm_ready);
            end else begin
                out_valid[s] = ~empty[s];
                pop[s]       = ~empty[s] & stOp__sti__lane_strm_ready[s];
            end
        end
    end

    always_comb begin
        lane_type_d = std__pe__lane_type;
        for (int s = 0; s < NUM_STRM; s++) begin
            push[s]       = std__pe__lane_strm_data_valid[s] & (~full[s] | pop[s]);
            overflow_d[s] = overflow_q[s] |
                            (std__pe__lane_strm_data_valid[s] & full[s] & ~pop[s]);
            count_next[s] = count[s] + {{AW{1'b0}}, push[s]} - {{AW{1'b0}}, pop[s]};
            ready_d[s]    = (count_next[s] < READY_LIMIT);
        end
    end

    // Framers only see entries that actually entered the FIFO.
    always_comb begin
        for (int s = 0; s < NUM_STRM; s++) begin
            fr_state_d[s]  = fr_state_q[s];
            msg_cnt_d[s]   = msg_cnt_q[s];
            frame_err_d[s] = frame_err_q[s];
            if (push[s]) begin
                case (cntl_e'(std__pe__lane_strm_cntl[2*s +: 2]))
                    CNTL_SOM: begin
                        if (fr_state_q[s] == IN_MSG) frame_err_d[s] = 1'b1;
                        fr_state_d[s] = IN_MSG;
                    end
                    CNTL_MOM: begin
                        if (fr_state_q[s] == IDLE) frame_err_d[s] = 1'b1;
                    end
                    CNTL_EOM: begin
                        if (fr_state_q[s] == IDLE) begin
                            frame_err_d[s] = 1'b1;
                        end else begin
                            fr_state_d[s] = IDLE;
                            msg_cnt_d[s]  = msg_cnt_q[s] + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    CNTL_SOM_EOM: begin
                        if (fr_state_q[s] == IN_MSG) frame_err_d[s] = 1'b1;
                        fr_state_d[s] = IDLE;
                        msg_cnt_d[s]  = msg_cnt_q[s] + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            ready_q     <= '0;
            frame_err_q <= '0;
            overflow_q  <= '0;
            lane_type_q <= '0;
            for (int s = 0; s < NUM_STRM; s++) begin
                fr_state_q[s] <= IDLE;
                msg_cnt_q[s]  <= '0;
            end
        end else begin
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            lane_type_q <= lane_type_d;
            for (int s = 0; s < NUM_STRM; s++) begin
                fr_state_q[s] <= fr_state_d[s];
                msg_cnt_q[s]  <= msg_cnt_d[s];
            end
        end
    end

    assign pe__std__lane_strm_ready        = ready_q;
    assign sti__stOp__lane_strm_data_valid = out_valid;
    assign sti__stOp__lane_type            = lane_type_q;
    assign strm_frame_err                  = frame_err_q;
    assign strm_overflow_err               = overflow_q;

endmodule

// File: tb/tb_std_lane_strm_buffer.sv
// tb/tb_std_lane_strm_buffer.sv - randomized and directed check of independent and lockstep lane buffers
module tb_std_lane_strm_buffer;
    localparam int NS    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SLACK = 2;
    localparam int CW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic [1:0]       lane_type;
    logic [NS-1:0]    in_valid;
    logic [2*NS-1:0]  in_cntl;
    logic [DW*NS-1:0] in_data, in_mask;
    logic [NS-1:0]    out_ready;

    // Index 0: independent streams, index 1: lockstep streams; both see identical stimulus.
    logic [NS-1:0]    rdy_o [2];
    logic [NS-1:0]    val_o [2];
    logic [NS-1:0]    ferr_o [2];
    logic [NS-1:0]    ovf_o [2];
    logic [2*NS-1:0]  cntl_o [2];
    logic [DW*NS-1:0] data_o [2];
    logic [DW*NS-1:0] mask_o [2];
    logic [1:0]       lt_o [2];
    logic [CW*NS-1:0] cnt_o [2];

    std_lane_strm_buffer #(.NUM_STRM(NS), .DATA_W(DW), .DEPTH(DEPTH), .SLACK(SLACK),
                           .CNT_W(CW), .LOCK_MODE(0)) dut (
        .clk(clk), .reset_poweron(resetn), .std__pe__lane_type(lane_type),
        .std__pe__lane_strm_data_valid(in_valid), .std__pe__lane_strm_cntl(in_cntl),
        .std__pe__lane_strm_data(in_data), .std__pe__lane_strm_data_mask(in_mask),
        .pe__std__lane_strm_ready(rdy_o[0]), .sti__stOp__lane_strm_data_valid(val_o[0]),
        .sti__stOp__lane_strm_cntl(cntl_o[0]), .sti__stOp__lane_strm_data(data_o[0]),
        .sti__stOp__lane_strm_data_mask(mask_o[0]), .stOp__sti__lane_strm_ready(out_ready),
        .sti__stOp__lane_type(lt_o[0]), .strm_msg_count(cnt_o[0]),
        .strm_frame_err(ferr_o[0]), .strm_overflow_err(ovf_o[0]));

    std_lane_strm_buffer #(.NUM_STRM(NS), .DATA_W(DW), .DEPTH(DEPTH), .SLACK(SLACK),
                           .CNT_W(CW), .LOCK_MODE(1)) dut_lock (
        .clk(clk), .reset_poweron(resetn), .std__pe__lane_type(lane_type),
        .std__pe__lane_strm_data_valid(in_valid), .std__pe__lane_strm_cntl(in_cntl),
        .std__pe__lane_strm_data(in_data), .std__pe__lane_strm_data_mask(in_mask),
        .pe__std__lane_strm_ready(rdy_o[1]), .sti__stOp__lane_strm_data_valid(val_o[1]),
        .sti__stOp__lane_strm_cntl(cntl_o[1]), .sti__stOp__lane_strm_data(data_o[1]),
        .sti__stOp__lane_strm_data_mask(mask_o[1]), .stOp__sti__lane_strm_ready(out_ready),
        .sti__stOp__lane_type(lt_o[1]), .strm_msg_count(cnt_o[1]),
        .strm_frame_err(ferr_o[1]), .strm_overflow_err(ovf_o[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: per-mode, per-stream queue of {cntl,data,mask} plus framing bookkeeping.
    logic [65:0] mq [2][NS][$];
    bit          in_msg [2][NS];
    logic [15:0] mcnt   [2][NS];
    bit          ferr_e [2][NS];
    bit          ovf_e  [2][NS];
    bit          rdy_e  [2][NS];
    logic [1:0]  lt_e;

    function automatic bit model_valid(int m, int s);
        bit all_v = 1'b1;
        for (int k = 0; k < NS; k++) if (mq[m][k].size() == 0) all_v = 1'b0;
        return (m == 1) ? all_v : (mq[m][s].size() != 0);
    endfunction

    task automatic frame(input int m, input int s, input logic [1:0] c);
        case (c)
            2'b01: begin if (in_msg[m][s]) ferr_e[m][s] = 1; in_msg[m][s] = 1; end
            2'b00: begin if (!in_msg[m][s]) ferr_e[m][s] = 1; end
            2'b10: begin
                if (!in_msg[m][s]) ferr_e[m][s] = 1;
                else begin in_msg[m][s] = 0; mcnt[m][s] = mcnt[m][s] + 16'd1; end
            end
            default: begin
                if (in_msg[m][s]) ferr_e[m][s] = 1;
                in_msg[m][s] = 0; mcnt[m][s] = mcnt[m][s] + 16'd1;
            end
        endcase
    endtask

    task automatic check_all();
        logic [65:0] hd;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("m%0d lane_type", m), lt_o[m], lt_e);
            for (int s = 0; s < NS; s++) begin
                check_eq($sformatf("m%0d s%0d valid", m, s), val_o[m][s], model_valid(m, s));
                check_eq($sformatf("m%0d s%0d ready", m, s), rdy_o[m][s], rdy_e[m][s]);
                check_eq($sformatf("m%0d s%0d msg_count", m, s), cnt_o[m][CW*s +: CW], mcnt[m][s]);
                check_eq($sformatf("m%0d s%0d frame_err", m, s), ferr_o[m][s], ferr_e[m][s]);
                check_eq($sformatf("m%0d s%0d overflow", m, s), ovf_o[m][s], ovf_e[m][s]);
                if (mq[m][s].size() != 0) begin
                    hd = mq[m][s][0];
                    check_eq($sformatf("m%0d s%0d head", m, s),
                             {cntl_o[m][2*s +: 2], data_o[m][DW*s +: DW], mask_o[m][DW*s +: DW]}, hd);
                end
            end
        end
    endtask

    // Applies the currently driven inputs for one clock, advances the model, then checks.
    task automatic cycle();
        bit pop [2][NS];
        bit all_r;
        int sz;
        all_r = &out_ready;
        for (int m = 0; m < 2; m++)
            for (int s = 0; s < NS; s++)
                pop[m][s] = model_valid(m, s) && ((m == 1) ? all_r : out_ready[s]);
        @(posedge clk);
        if (!resetn) begin
            lt_e = 2'b00;
            for (int m = 0; m < 2; m++)
                for (int s = 0; s < NS; s++) begin
                    mq[m][s].delete();
                    in_msg[m][s] = 0; mcnt[m][s] = 0; ferr_e[m][s] = 0;
                    ovf_e[m][s] = 0;  rdy_e[m][s] = 0;
                end
        end else begin
            lt_e = lane_type;
            for (int m = 0; m < 2; m++)
                for (int s = 0; s < NS; s++) begin
                    sz = mq[m][s].size();
                    if (pop[m][s]) void'(mq[m][s].pop_front());
                    if (in_valid[s]) begin
                        if (sz < DEPTH || pop[m][s]) begin
                            mq[m][s].push_back({in_cntl[2*s +: 2], in_data[DW*s +: DW], in_mask[DW*s +: DW]});
                            frame(m, s, in_cntl[2*s +: 2]);
                        end else begin
                            ovf_e[m][s] = 1;
                        end
                    end
                    rdy_e[m][s] = (mq[m][s].size() < DEPTH - SLACK);
                end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_in();
        in_valid = '0; in_cntl = '0; in_data = '0; in_mask = '0;
    endtask

    task automatic set_in(input int s, input logic [1:0] c, input logic [31:0] d);
        in_valid[s] = 1'b1;
        in_cntl[2*s +: 2] = c;
        in_data[DW*s +: DW] = d;
        in_mask[DW*s +: DW] = ~d;
    endtask

    task automatic do_reset();
        idle_in();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
    endtask

    int phase;
    int vp;
    int rp;

    initial begin
        resetn = 1'b0; lane_type = 2'b00; out_ready = '0;
        idle_in();
        @(negedge clk);
        cycle();
        check_eq("reset valid", val_o[0], 2'b00);
        check_eq("reset ready", rdy_o[0], 2'b00);
        resetn = 1'b1;
        cycle();
        check_eq("ready after release", rdy_o[0], 2'b11);

        // Single message through stream 0 with the consumer always ready.
        out_ready = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            idle_in();
            set_in(0, (i == 1) ? 2'b01 : (i == 2) ? 2'b00 : 2'b10, i);
            cycle();
            check_eq($sformatf("t1 head %0d", i), data_o[0][31:0], i);
        end
        check_eq("t1 msg_count", cnt_o[0][15:0], 16'd1);
        check_eq("t1 frame_err", ferr_o[0][0], 1'b0);
        idle_in();
        cycle();

        // Fill with a stalled consumer: slack, drop at full.
        do_reset();
        out_ready = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            idle_in();
            set_in(0, (i == 1) ? 2'b01 : 2'b00, i);
            cycle();
            check_eq($sformatf("t2 ready after push %0d", i), rdy_o[0][0], (i < 6));
        end
        check_eq("t2 overflow", ovf_o[0][0], 1'b1);
        check_eq("t2 head", data_o[0][31:0], 32'h1);

        // Push and pop together at full.
        do_reset();
        out_ready = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            idle_in(); set_in(0, 2'b00, i); cycle();
        end
        idle_in(); set_in(0, 2'b00, 9); out_ready = 2'b01; cycle();
        check_eq("t6 overflow", ovf_o[0][0], 1'b0);
        check_eq("t6 head", data_o[0][31:0], 32'h2);
        check_eq("t6 ready", rdy_o[0][0], 1'b0);
        out_ready = 2'b00;

        // Lockstep alignment.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle_in(); set_in(0, 2'b00, 32'h10 + i); cycle();
        end
        check_eq("t3 no valid", val_o[1], 2'b00);
        idle_in(); set_in(1, 2'b00, 32'h20); cycle();
        check_eq("t3 both valid", val_o[1], 2'b11);
        idle_in(); out_ready = 2'b11; cycle();
        out_ready = 2'b00;
        check_eq("t3 after joint pop", val_o[1], 2'b00);
        check_eq("t3 s0 head", data_o[1][31:0], 32'h11);

        // Framing errors.
        do_reset();
        out_ready = 2'b11;
        idle_in(); set_in(0, 2'b00, 32'hA); cycle();
        check_eq("t4 mom in idle", ferr_o[0][0], 1'b1);
        idle_in(); set_in(0, 2'b01, 32'hB); cycle();
        idle_in(); set_in(0, 2'b01, 32'hC); cycle();
        idle_in(); set_in(0, 2'b10, 32'hD); cycle();
        check_eq("t4 msg_count", cnt_o[0][15:0], 16'd1);
        check_eq("t4 sticky", ferr_o[0][0], 1'b1);

        // Reset mid-message.
        do_reset();
        out_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            idle_in(); set_in(0, (i == 0) ? 2'b01 : 2'b00, 32'h30 + i); cycle();
        end
        resetn = 1'b0; idle_in(); set_in(0, 2'b00, 32'h99); cycle();
        check_eq("t5 valid", val_o[0], 2'b00);
        check_eq("t5 count", cnt_o[0], '0);
        check_eq("t5 ready in reset", rdy_o[0], 2'b00);
        resetn = 1'b1; idle_in(); cycle();
        check_eq("t5 ready", rdy_o[0], 2'b11);
        idle_in(); set_in(0, 2'b10, 32'h40); cycle();
        check_eq("t5 framer idle", ferr_o[0][0], 1'b1);

        // Random traffic across phases of varying consumer backpressure.
        for (int i = 0; i < 4000; i++) begin
            phase = (i / 250) % 4;
            vp = (phase == 0) ? 1 : 3;
            rp = (phase == 1) ? 0 : (phase == 2) ? 1 : 3;
            resetn = ($urandom_range(0, 599) != 0);
            lane_type = 2'($urandom);
            for (int s = 0; s < NS; s++) begin
                in_valid[s]  = ($urandom_range(0, 3) < vp);
                out_ready[s] = ($urandom_range(0, 3) < rp) || (phase == 3);
                in_cntl[2*s +: 2]   = 2'($urandom);
                in_data[DW*s +: DW] = $urandom;
                in_mask[DW*s +: DW] = $urandom;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
